// File: rtl/mcu_pkg.sv
// mcu_pkg: shared constants for the multi-cycle MIPS main control unit.
// Holds the 4-bit state encoding, opcode constants, ALU op codes, pc_src and
// alu_src_b mux codes, fault codes and a helper that flags the states that
// wait on the memory handshake.
package mcu_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_EXEC   = 4'd6;
    localparam state_t S_ALUWB  = 4'd7;
    localparam state_t S_BRANCH = 4'd8;
    localparam state_t S_JUMP   = 4'd9;
    localparam state_t S_ADDIEX = 4'd10;
    localparam state_t S_ADDIWB = 4'd11;
    localparam state_t S_TRAP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_MEMTO   = 2'b10;

    // States that stall on mem_ready and therefore run the wait counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mcu_out_dec.sv
// mcu_out_dec: combinational decode of the FSM state into the datapath
// control strobes (Moore outputs).
// Ports:
//   state      - current FSM state
//   fetch_rdy  - mem_ready already gated by reset; drives pc_wr/ir_wr in FETCH
//   pc_wr .. alu_op - datapath control strobes
module mcu_out_dec
    import mcu_pkg::*;
#(
    parameter int ALUOP_W = 2
) (
    input  state_t             state,
    input  logic               fetch_rdy,
    output logic               pc_wr,
    output logic               pc_wr_cond,
    output logic [1:0]         pc_src,
    output logic               i_or_d,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ir_wr,
    output logic               reg_dst,
    output logic               reg_wr,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op
);

    logic [1:0] alu_code;

    assign alu_op = ALUOP_W'(alu_code);

    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        pc_src     = PC_SRC_ALU;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_code   = ALU_ADD;

        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_wr     = fetch_rdy;
                pc_wr     = fetch_rdy;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                i_or_d = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_code  = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_code   = ALU_SUB;
                pc_wr_cond = 1'b1;
                pc_src     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = PC_SRC_JUMP;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_wr = 1'b1;
            end
            default: begin
                // TRAP and unused encodings: everything stays at its default.
            end
        endcase
    end

endmodule

// File: rtl/mcu_fsm.sv
// mcu_fsm: multi-cycle main control unit for the MIPS core. Sequences each
// instruction through fetch/decode/execute/memory/writeback, with a memory
// ready handshake, optional wait timeout and a sticky fault trap.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   op                - opcode from the instruction register
//   mem_ready         - memory completes/accepts the access this cycle
//   pc_wr .. alu_op   - datapath control strobes (from mcu_out_dec)
//   fault, fault_code - sticky trap flag and cause
//   state             - current state, for debug
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4; waits on mem_ready
// DECODE | read registers, compute branch target, dispatch on opcode
// MEMADR | compute lw/sw effective address
// MEMRD  | data memory read; waits on mem_ready
// MEMWB  | write loaded data to rt
// MEMWR  | data memory write; waits on mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare rs/rt, conditional PC write
// JUMP   | unconditional PC write with jump target
// ADDIEX | addi ALU operation
// ADDIWB | write addi result to rt
// TRAP   | illegal opcode or memory timeout; left only by reset
module mcu_fsm
    import mcu_pkg::*;
#(
    parameter int ALUOP_W  = 2,
    parameter int IMM_EN   = 1,
    parameter int WAIT_MAX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pc_wr,
    output logic               pc_wr_cond,
    output logic [1:0]         pc_src,
    output logic               i_or_d,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ir_wr,
    output logic               reg_dst,
    output logic               reg_wr,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [3:0]         state
);

    localparam int             CW      = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(WAIT_MAX);

    state_t        state_q;
    state_t        state_nxt;
    logic [CW-1:0] cnt_q;
    logic          fault_q;
    logic [1:0]    fault_code_q;
    logic [1:0]    code_nxt;
    logic          waiting;
    logic          timeout;
    logic          fetch_rdy;

    assign waiting = is_wait_state(state_q);
    // mem_ready arriving on the last allowed cycle wins over the timeout.
    assign timeout = (WAIT_MAX > 0) && waiting && !mem_ready && (cnt_q == CNT_MAX);

    always_comb begin
        state_nxt = state_q;
        code_nxt  = fault_code_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    code_nxt  = FAULT_MEMTO;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI: begin
                        if (IMM_EN != 0) begin
                            state_nxt = S_ADDIEX;
                        end else begin
                            state_nxt = S_TRAP;
                            code_nxt  = FAULT_ILLEGAL;
                        end
                    end
                    default: begin
                        state_nxt = S_TRAP;
                        code_nxt  = FAULT_ILLEGAL;
                    end
                endcase
            end
            // op is stable until the next FETCH, so anything not lw here is sw.
            S_MEMADR: state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_nxt = S_MEMWB;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    code_nxt  = FAULT_MEMTO;
                end
            end
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    code_nxt  = FAULT_MEMTO;
                end
            end
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_nxt;
            fault_code_q <= code_nxt;
            fault_q      <= fault_q | (state_nxt == S_TRAP);
            // Counter saturates at CNT_MAX; with WAIT_MAX=0 it stays at zero.
            if ((state_nxt != state_q) || mem_ready || !waiting) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // pc_wr/ir_wr must stay low while reset is held, even with mem_ready high.
    assign fetch_rdy  = mem_ready & rst_n;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign state      = state_q;

    mcu_out_dec #(
        .ALUOP_W (ALUOP_W)
    ) u_out_dec (
        .state      (state_q),
        .fetch_rdy  (fetch_rdy),
        .pc_wr      (pc_wr),
        .pc_wr_cond (pc_wr_cond),
        .pc_src     (pc_src),
        .i_or_d     (i_or_d),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_wr      (ir_wr),
        .reg_dst    (reg_dst),
        .reg_wr     (reg_wr),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op)
    );

endmodule

// File: tb/tb_mcu_fsm.sv
// tb_mcu_fsm: scoreboard bench for mcu_fsm. Instance A uses default
// parameters; instance B uses IMM_EN=0, WAIT_MAX=3, ALUOP_W=3. Each stimulus
// step pushes the hand-listed expected state plus the expected strobes into
// a queue; a monitor pops and compares on the falling edge.
module tb_mcu_fsm;
    import mcu_pkg::*;

    localparam logic [5:0] OP_BAD = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       a_rst_n, a_rdy;
    logic [5:0] a_op;
    logic       a_pc_wr, a_pc_wr_cond, a_i_or_d, a_mem_rd, a_mem_wr, a_ir_wr;
    logic       a_reg_dst, a_reg_wr, a_mem_to_reg, a_alu_src_a, a_fault;
    logic [1:0] a_pc_src, a_alu_src_b, a_alu_op, a_fault_code;
    logic [3:0] a_state;

    // Instance B signals
    logic       b_rst_n, b_rdy;
    logic [5:0] b_op;
    logic       b_pc_wr, b_pc_wr_cond, b_i_or_d, b_mem_rd, b_mem_wr, b_ir_wr;
    logic       b_reg_dst, b_reg_wr, b_mem_to_reg, b_alu_src_a, b_fault;
    logic [1:0] b_pc_src, b_alu_src_b, b_fault_code;
    logic [2:0] b_alu_op;
    logic [3:0] b_state;

    mcu_fsm dut_a (
        .clk(clk), .rst_n(a_rst_n), .op(a_op), .mem_ready(a_rdy),
        .pc_wr(a_pc_wr), .pc_wr_cond(a_pc_wr_cond), .pc_src(a_pc_src),
        .i_or_d(a_i_or_d), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .ir_wr(a_ir_wr),
        .reg_dst(a_reg_dst), .reg_wr(a_reg_wr), .mem_to_reg(a_mem_to_reg),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
        .fault(a_fault), .fault_code(a_fault_code), .state(a_state)
    );

    mcu_fsm #(.ALUOP_W(3), .IMM_EN(0), .WAIT_MAX(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .op(b_op), .mem_ready(b_rdy),
        .pc_wr(b_pc_wr), .pc_wr_cond(b_pc_wr_cond), .pc_src(b_pc_src),
        .i_or_d(b_i_or_d), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .ir_wr(b_ir_wr),
        .reg_dst(b_reg_dst), .reg_wr(b_reg_wr), .mem_to_reg(b_mem_to_reg),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .fault(b_fault), .fault_code(b_fault_code), .state(b_state)
    );

    logic [23:0] a_act, b_act;
    assign a_act = {a_pc_wr, a_pc_wr_cond, a_pc_src, a_i_or_d, a_mem_rd, a_mem_wr,
                    a_ir_wr, a_reg_dst, a_reg_wr, a_mem_to_reg, a_alu_src_a,
                    a_alu_src_b, {1'b0, a_alu_op}, a_fault, a_fault_code, a_state};
    assign b_act = {b_pc_wr, b_pc_wr_cond, b_pc_src, b_i_or_d, b_mem_rd, b_mem_wr,
                    b_ir_wr, b_reg_dst, b_reg_wr, b_mem_to_reg, b_alu_src_a,
                    b_alu_src_b, b_alu_op, b_fault, b_fault_code, b_state};

    // Expected strobes written out from the per-state output table.
    function automatic logic [23:0] exp_vec(input logic [3:0] st, input logic rdy,
                                            input logic rstn, input logic f,
                                            input logic [1:0] fc);
        logic pw, pwc, iod, mr, mw, irw, rd, rw, m2r, sa;
        logic [1:0] ps, sb;
        logic [2:0] ao;
        {pw, pwc, iod, mr, mw, irw, rd, rw, m2r, sa} = '0;
        ps = 2'b00; sb = 2'b00; ao = 3'd0;
        case (st)
            S_FETCH:  begin mr = 1; sb = 2'b01; irw = rdy & rstn; pw = rdy & rstn; end
            S_DECODE: sb = 2'b11;
            S_MEMADR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  begin mr = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mw = 1; iod = 1; end
            S_EXEC:   begin sa = 1; ao = 3'd2; end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_BRANCH: begin sa = 1; ao = 3'd1; pwc = 1; ps = 2'b01; end
            S_JUMP:   begin pw = 1; ps = 2'b10; end
            S_ADDIEX: begin sa = 1; sb = 2'b10; end
            S_ADDIWB: rw = 1;
            default:  ;
        endcase
        return {pw, pwc, ps, iod, mr, mw, irw, rd, rw, m2r, sa, sb, ao, f, fc, st};
    endfunction

    logic [23:0] qa[$], qb[$];
    int          na[$], nb[$];
    int          a_steps = 0, b_steps = 0;
    int          checks = 0, errors = 0;
    logic [23:0] mon_e;
    int          mon_n;

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            mon_e = qa.pop_front();
            mon_n = na.pop_front();
            checks++;
            if (a_act !== mon_e) begin
                errors++;
                $display("FAIL a_step%0d actual=%h expected=%h", mon_n, a_act, mon_e);
            end
        end
        if (qb.size() > 0) begin
            mon_e = qb.pop_front();
            mon_n = nb.pop_front();
            checks++;
            if (b_act !== mon_e) begin
                errors++;
                $display("FAIL b_step%0d actual=%h expected=%h", mon_n, b_act, mon_e);
            end
        end
    end

    // One cycle of stimulus; st is the state expected during this cycle.
    task automatic step_a(input logic [5:0] o, input logic r, input logic rs,
                          input logic [3:0] st, input logic f, input logic [1:0] fc);
        @(posedge clk);
        #1;
        a_op = o; a_rdy = r; a_rst_n = rs;
        qa.push_back(exp_vec(st, r, rs, f, fc));
        na.push_back(a_steps);
        a_steps++;
    endtask

    task automatic step_b(input logic [5:0] o, input logic r, input logic rs,
                          input logic [3:0] st, input logic f, input logic [1:0] fc);
        @(posedge clk);
        #1;
        b_op = o; b_rdy = r; b_rst_n = rs;
        qb.push_back(exp_vec(st, r, rs, f, fc));
        nb.push_back(b_steps);
        b_steps++;
    endtask

    task automatic a_ok(input logic [5:0] o, input logic r, input logic [3:0] st);
        step_a(o, r, 1'b1, st, 1'b0, 2'b00);
    endtask

    task automatic b_ok(input logic [5:0] o, input logic r, input logic [3:0] st);
        step_b(o, r, 1'b1, st, 1'b0, 2'b00);
    endtask

    initial begin
        a_rst_n = 1'b0; a_rdy = 1'b1; a_op = OP_LW;
        b_rst_n = 1'b0; b_rdy = 1'b1; b_op = OP_LW;

        // ---------------- Instance A ----------------
        // Reset with mem_ready high: FETCH outputs but pc_wr/ir_wr low.
        step_a(OP_LW, 1, 0, S_FETCH, 0, 2'b00);
        step_a(OP_LW, 1, 0, S_FETCH, 0, 2'b00);
        // lw, zero wait: 5 cycles
        a_ok(OP_LW, 1, S_FETCH); a_ok(OP_LW, 1, S_DECODE); a_ok(OP_LW, 1, S_MEMADR);
        a_ok(OP_LW, 1, S_MEMRD); a_ok(OP_LW, 1, S_MEMWB);
        // sw with two wait cycles in MEMWR
        a_ok(OP_SW, 1, S_FETCH); a_ok(OP_SW, 1, S_DECODE); a_ok(OP_SW, 1, S_MEMADR);
        a_ok(OP_SW, 0, S_MEMWR); a_ok(OP_SW, 0, S_MEMWR); a_ok(OP_SW, 1, S_MEMWR);
        // R-type, beq, j, addi
        a_ok(OP_RTYPE, 1, S_FETCH); a_ok(OP_RTYPE, 1, S_DECODE);
        a_ok(OP_RTYPE, 1, S_EXEC);  a_ok(OP_RTYPE, 1, S_ALUWB);
        a_ok(OP_BEQ, 1, S_FETCH); a_ok(OP_BEQ, 1, S_DECODE); a_ok(OP_BEQ, 1, S_BRANCH);
        a_ok(OP_J, 1, S_FETCH);   a_ok(OP_J, 1, S_DECODE);   a_ok(OP_J, 1, S_JUMP);
        a_ok(OP_ADDI, 1, S_FETCH); a_ok(OP_ADDI, 1, S_DECODE);
        a_ok(OP_ADDI, 1, S_ADDIEX); a_ok(OP_ADDI, 1, S_ADDIWB);
        // Fetch waits never time out when WAIT_MAX=0
        for (int i = 0; i < 5; i++) a_ok(OP_LW, 0, S_FETCH);
        a_ok(OP_LW, 1, S_FETCH); a_ok(OP_LW, 1, S_DECODE); a_ok(OP_LW, 1, S_MEMADR);
        a_ok(OP_LW, 0, S_MEMRD); a_ok(OP_LW, 0, S_MEMRD);
        // Reset mid-MEMRD takes effect in the same cycle
        step_a(OP_LW, 1, 0, S_FETCH, 0, 2'b00);
        // Illegal opcode -> TRAP, strobes 0 for 20 cycles
        a_ok(OP_BAD, 1, S_FETCH); a_ok(OP_BAD, 1, S_DECODE);
        for (int i = 0; i < 20; i++) step_a(OP_BAD, i[0], 1, S_TRAP, 1, 2'b01);
        // Reset while in TRAP clears the fault; fetch resumes
        step_a(OP_LW, 1, 0, S_FETCH, 0, 2'b00);
        a_ok(OP_LW, 1, S_FETCH); a_ok(OP_LW, 1, S_DECODE); a_ok(OP_LW, 1, S_MEMADR);
        step_a(OP_LW, 1, 0, S_FETCH, 0, 2'b00);

        // ---------------- Instance B ----------------
        step_b(OP_ADDI, 1, 0, S_FETCH, 0, 2'b00);
        step_b(OP_ADDI, 1, 0, S_FETCH, 0, 2'b00);
        // addi illegal when IMM_EN=0
        b_ok(OP_ADDI, 1, S_FETCH); b_ok(OP_ADDI, 1, S_DECODE);
        for (int i = 0; i < 3; i++) step_b(OP_ADDI, 1, 1, S_TRAP, 1, 2'b01);
        step_b(OP_LW, 1, 0, S_FETCH, 0, 2'b00);
        // MEMRD timeout after the 4th wait cycle
        b_ok(OP_LW, 1, S_FETCH); b_ok(OP_LW, 1, S_DECODE); b_ok(OP_LW, 1, S_MEMADR);
        for (int i = 0; i < 4; i++) b_ok(OP_LW, 0, S_MEMRD);
        step_b(OP_LW, 0, 1, S_TRAP, 1, 2'b10);
        step_b(OP_LW, 1, 1, S_TRAP, 1, 2'b10);
        step_b(OP_LW, 1, 0, S_FETCH, 0, 2'b00);
        // mem_ready on the 4th wait cycle wins over the timeout
        b_ok(OP_LW, 1, S_FETCH); b_ok(OP_LW, 1, S_DECODE); b_ok(OP_LW, 1, S_MEMADR);
        for (int i = 0; i < 3; i++) b_ok(OP_LW, 0, S_MEMRD);
        b_ok(OP_LW, 1, S_MEMRD); b_ok(OP_LW, 1, S_MEMWB);
        // R-type with 3-bit alu_op (FUNCT zero-extended)
        b_ok(OP_RTYPE, 1, S_FETCH); b_ok(OP_RTYPE, 1, S_DECODE);
        b_ok(OP_RTYPE, 1, S_EXEC);  b_ok(OP_RTYPE, 1, S_ALUWB);
        // FETCH timeout
        for (int i = 0; i < 4; i++) b_ok(OP_LW, 0, S_FETCH);
        step_b(OP_LW, 0, 1, S_TRAP, 1, 2'b10);
        step_b(OP_LW, 1, 0, S_FETCH, 0, 2'b00);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d/%0d pending, required 0/0",
                     qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
